paddsb_pipe: RTL and testbench
==============================

PADDSB_PIPE -- requirements
Module: paddsb_pipe

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, synchronous and active-low; sampled only on rising clk.
REQ-003 SHALL: in_valid  input  1  operand pair A/B valid this cycle.
REQ-004 SHALL: in_ready  output  1  block can accept an operand pair this cycle.
REQ-005 SHALL: A, B  input  16 each  operands; four signed 4-bit lanes, [3:0] .. [15:12].
REQ-006 SHALL: out_valid  output  1  head result present.
REQ-007 SHALL: out_ready  input  1  consumer takes head result this cycle.
REQ-008 SHALL: Result  output  16  saturated lane-wise sum at FIFO head.
REQ-009 SHALL: Sat  output  4  per-lane saturation flags of head entry; bit i = lane i.
REQ-010 SHALL: V  output  1  sticky-per-pop overflow flag, i.e. OR of Sat of last popped entry.
REQ-011 SHALL: clr_cnt  input  1  synchronous clear of sat_cnt.
REQ-012 SHALL: sat_cnt  output  8  count of accepted pairs with any lane saturated.

Function
REQ-013 SHALL: accept a pair when in_valid && in_ready at a rising edge; no other cycle accepts.
REQ-014 SHALL: compute each lane as the signed 4-bit sum of A and B lane, range -8..+7, lanes independent, with no carry between lanes.
REQ-015 SHALL: saturate lane sums > +7 to 4'h7 and < -8 to 4'h8, and set the lane's Sat bit; otherwise Sat bit 0 and wrapped sum equals true sum.
REQ-016 SHALL: store {Result, Sat} of each accepted pair in a 2-entry in-order FIFO.
REQ-017 SHALL: latency 1 -- a pair accepted at edge N is visible at head (out_valid=1) after edge N when FIFO was empty.
REQ-018 SHALL: in_ready = (occupancy != 2), derived from registered occupancy only; no same-cycle credit from a pop.
REQ-019 SHALL: out_valid = (occupancy != 0); Result/Sat undefined-free (hold last entry data) when out_valid=0 is not required; bench ignores them.
REQ-020 SHALL: pop head when out_valid && out_ready; Result/Sat/out_valid hold stable while out_valid && !out_ready.
REQ-021 SHALL: simultaneous push and pop at occupancy 1 -- occupancy stays 1, new entry becomes head next cycle.
REQ-022 SHALL: at occupancy 2 with pop, no push occurs that cycle (in_ready=0); occupancy becomes 1.
REQ-023 SHALL: on pop, V <= OR of popped Sat; V unchanged when no pop.
REQ-024 SHALL: sat_cnt increments by 1 on each accept with any lane saturated, saturating at 255 (no wrap).
REQ-025 SHALL: clr_cnt=1 sets sat_cnt to 0 next edge; clear wins over a simultaneous increment.
REQ-026 SHALL: pointers wrap modulo 2; no entry lost or duplicated under any push/pop sequence.

Reset
REQ-027 SHALL: rst_n=0 at an edge sets occupancy 0, pointers 0, V=0, sat_cnt=0; hence out_valid=0, in_ready=1 after that edge.
REQ-028 SHALL: reset mid-operation discards all buffered entries; an in_valid in the reset cycle is not accepted.
REQ-029 SHALL: reset dominates clr_cnt, push and pop.

Verification
REQ-030 SHALL: A=0x1234, B=0x1111, out_ready=1 -> next cycle out_valid=1, Result=0x2345, Sat=0x0; after pop V=0.
REQ-031 SHALL: A=0x7777, B=0x1111 -> Result=0x7777, Sat=0xF, sat_cnt 0->1; after pop V=1.
REQ-032 SHALL: A=0x8888, B=0x8888 -> Result=0x8888, Sat=0xF; A=0x7F00, B=0x0100 -> Result=0x7000, Sat=0x0.
REQ-033 SHALL: out_ready=0, three back-to-back valid pairs -> first two accepted, in_ready=0 on third until a pop; results emerge in order, unchanged while stalled.
REQ-034 SHALL: 256 saturating pairs -> sat_cnt holds 255; clr_cnt asserted with a saturating accept -> sat_cnt=0.
REQ-035 SHALL: rst_n=0 with 2 entries buffered -> out_valid=0, in_ready=1, V=0, sat_cnt=0 after the edge.

Source files
------------

// File: rtl/paddsb_pipe.sv
// ---------------------------------------------------------------------------
// paddsb_pipe
//
// Packed saturating add of four signed 4-bit lanes. Results are buffered in a
// 2-entry in-order FIFO together with their per-lane saturation flags.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. Nothing else transfers data. Ready never
// depends on valid in the same cycle. Once out_valid is high, Result and Sat
// hold until that entry is popped.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair A/B offered this cycle
//   in_ready   FIFO has room (registered occupancy != 2)
//   A, B       operands, lanes [3:0], [7:4], [11:8], [15:12]
//   out_valid  head entry present (occupancy != 0)
//   out_ready  consumer takes the head entry this cycle
//   Result     saturated lane-wise sum of the head entry
//   Sat        per-lane saturation flags of the head entry (bit i = lane i)
//   V          OR of Sat of the most recently popped entry
//   clr_cnt    synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt    number of accepted pairs with any lane saturated, stops at 255
// ---------------------------------------------------------------------------
module paddsb_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Result,
    output logic [3:0]  Sat,
    output logic        V,
    input  logic        clr_cnt,
    output logic [7:0]  sat_cnt
);

    // -----------------------------------------------------------------------
    // Lane arithmetic
    // -----------------------------------------------------------------------
    logic [15:0] lane_res;
    logic [3:0]  lane_ovf;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [4:0] ext_sum;

        // Sign-extend to 5 bits so the true sum -16..+14 is representable.
        assign ext_sum = {A[4*i+3], A[4*i +: 4]} + {B[4*i+3], B[4*i +: 4]};

        // The sum fits in 4 bits exactly when the top two bits agree.
        assign lane_ovf[i] = ext_sum[4] ^ ext_sum[3];

        // ext_sum[4] is the true sign: negative overflow clamps to -8.
        assign lane_res[4*i +: 4] = lane_ovf[i] ? (ext_sum[4] ? 4'h8 : 4'h7)
                                                : ext_sum[3:0];
    end

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    logic [19:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic        push;
    logic        pop;

    // Both readies come from registered occupancy only, so a pop in the same
    // cycle does not free a slot for a push when the FIFO is full.
    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign Result = mem[rd_ptr][19:4];
    assign Sat    = mem[rd_ptr][3:0];

    // Storage carries no reset: entries are only ever read when occupancy
    // says they are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= {lane_res, lane_ovf};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            V      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                V      <= |mem[rd_ptr][3:0];
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Saturation event counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt <= 8'd0;
        end else if (clr_cnt) begin
            sat_cnt <= 8'd0;
        end else if (push && (|lane_ovf) && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_paddsb_pipe.sv
// ---------------------------------------------------------------------------
// tb_paddsb_pipe
//
// Drives paddsb_pipe one cycle at a time. Expected {Result, Sat} entries are
// pushed to exp_q when a pair is accepted and compared against the head while
// it is visible and when it is popped. V and sat_cnt are tracked alongside.
// ---------------------------------------------------------------------------
module tb_paddsb_pipe;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Result;
    logic [3:0]  Sat;
    logic        V;
    logic        clr_cnt;
    logic [7:0]  sat_cnt;

    always #5 clk = ~clk;

    paddsb_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Sat       (Sat),
        .V         (V),
        .clr_cnt   (clr_cnt),
        .sat_cnt   (sat_cnt)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [19:0] exp_q[$];
    logic        exp_v;
    int          exp_cnt;
    int          n_checks;
    int          n_fails;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference lane adder: true integer sum, then clamp.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic [3:0]  s;
        logic signed [3:0] la;
        logic signed [3:0] lb;
        int ai, bi, sum;
        r = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            la  = a[4*i +: 4];
            lb  = b[4*i +: 4];
            ai  = la;
            bi  = lb;
            sum = ai + bi;
            if (sum > 7) begin
                r[4*i +: 4] = 4'h7;
                s[i] = 1'b1;
            end else if (sum < -8) begin
                r[4*i +: 4] = 4'h8;
                s[i] = 1'b1;
            end else begin
                r[4*i +: 4] = sum[3:0];
            end
        end
        return {r, s};
    endfunction

    // -----------------------------------------------------------------------
    // One clock cycle with the currently driven inputs
    // -----------------------------------------------------------------------
    task automatic step();
        logic [19:0] e;
        logic [19:0] ne;
        logic        do_pop;
        logic        do_push;
        @(negedge clk);
        if (rst_n) begin
            check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() != 2});
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            check_eq("v", {31'd0, V}, {31'd0, exp_v});
            check_eq("sat_cnt", {24'd0, sat_cnt}, exp_cnt);
            if (exp_q.size() != 0) begin
                check_eq("result", {16'd0, Result}, {16'd0, exp_q[0][19:4]});
                check_eq("sat", {28'd0, Sat}, {28'd0, exp_q[0][3:0]});
            end
            do_pop  = (exp_q.size() != 0) && out_ready;
            do_push = in_valid && (exp_q.size() != 2);
            ne = model(A, B);
            if (do_pop) begin
                e = exp_q.pop_front();
                exp_v = |e[3:0];
            end
            if (do_push) exp_q.push_back(ne);
            if (clr_cnt) exp_cnt = 0;
            else if (do_push && (|ne[3:0]) && exp_cnt < 255) exp_cnt++;
        end else begin
            exp_q.delete();
            exp_v   = 1'b0;
            exp_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic drive(input logic vld, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy);
        in_valid  = vld;
        A         = a;
        B         = b;
        out_ready = ordy;
        step();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, ordy);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        n_checks  = 0;
        n_fails   = 0;
        exp_v     = 1'b0;
        exp_cnt   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        A         = '0;
        B         = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed operand patterns, one at a time, drained in between.
        drive(1'b1, 16'h1234, 16'h1111, 1'b1);
        check_eq("basic_result", {16'd0, Result}, 32'h2345);
        idle(2, 1'b1);
        check_eq("basic_v", {31'd0, V}, 32'd0);
        drive(1'b1, 16'h7777, 16'h1111, 1'b1);
        check_eq("possat_result", {16'd0, Result}, 32'h7777);
        check_eq("possat_sat", {28'd0, Sat}, 32'hF);
        check_eq("possat_cnt", {24'd0, sat_cnt}, 32'd1);
        idle(2, 1'b1);
        check_eq("possat_v", {31'd0, V}, 32'd1);
        drive(1'b1, 16'h8888, 16'h8888, 1'b1);
        check_eq("negsat_result", {16'd0, Result}, 32'h8888);
        idle(1, 1'b1);
        drive(1'b1, 16'h7F00, 16'h0100, 1'b1);
        check_eq("mixed_result", {16'd0, Result}, 32'h7000);
        check_eq("mixed_sat", {28'd0, Sat}, 32'h0);
        idle(2, 1'b1);

        // Back-pressure: three pairs while stalled, the third waits.
        drive(1'b1, 16'h0123, 16'h0101, 1'b0);
        drive(1'b1, 16'h4567, 16'h0202, 1'b0);
        drive(1'b1, 16'h89AB, 16'h0303, 1'b0);
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 16'h89AB, 16'h0303, 1'b0);
        drive(1'b1, 16'h89AB, 16'h0303, 1'b1);
        drive(1'b1, 16'h89AB, 16'h0303, 1'b1);
        idle(4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hFFFF)),
                  16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
        end
        idle(3, 1'b1);

        // Counter saturation and clear priority.
        clr_cnt = 1'b1;
        idle(1, 1'b1);
        clr_cnt = 1'b0;
        for (int i = 0; i < 260; i++) drive(1'b1, 16'h7777, 16'h1111, 1'b1);
        check_eq("cnt_hold_255", {24'd0, sat_cnt}, 32'd255);
        clr_cnt = 1'b1;
        drive(1'b1, 16'h8888, 16'h8888, 1'b1);
        clr_cnt = 1'b0;
        check_eq("cnt_clr_wins", {24'd0, sat_cnt}, 32'd0);
        idle(3, 1'b1);

        // Reset with two entries buffered and a pair offered.
        drive(1'b1, 16'h7777, 16'h7777, 1'b0);
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        idle(1, 1'b1);
        drive(1'b1, 16'h8888, 16'h8000, 1'b0);
        drive(1'b1, 16'h1111, 16'h2222, 1'b0);
        check_eq("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        drive(1'b1, 16'h7777, 16'h7777, 1'b1);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mid_rst_v", {31'd0, V}, 32'd0);
        check_eq("mid_rst_cnt", {24'd0, sat_cnt}, 32'd0);
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
        idle(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
